// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg -- parametrised UART receiver with majority-vote sampling,
// framing/overrun detection and a valid/ready output handshake.
//
// Optional feature macro: UART_RX_PARITY_EN
//   defined   : one parity bit follows the data bits and is checked
//               against PARITY_ODD (0 = even, 1 = odd).
//   undefined : no parity bit in the frame, o_Parity_Err tied low.
//
// Ports:
//   i_Clock       system clock, rising edge
//   i_Reset       synchronous active-high reset
//   i_RX_Serial   asynchronous serial line, idle high
//   i_RX_Ready    consumer accepts the held word while o_RX_Valid is high
//   o_RX_Valid    a received word is held on o_RX_Byte
//   o_RX_Byte     received data, LSB first on the line
//   o_Frame_Err   a stop bit was sampled low (qualified by o_RX_Valid)
//   o_Parity_Err  parity mismatch (qualified by o_RX_Valid)
//   o_Overrun     sticky: a completed frame was dropped; cleared on handshake
//   o_Busy        receiver FSM is not idle
module uart_rx_cfg #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic                 i_RX_Serial,
  input  logic                 i_RX_Ready,
  output logic                 o_RX_Valid,
  output logic [DATA_BITS-1:0] o_RX_Byte,
  output logic                 o_Frame_Err,
  output logic                 o_Parity_Err,
  output logic                 o_Overrun,
  output logic                 o_Busy
);

  localparam int CW  = $clog2(CLKS_PER_BIT);
  localparam int IW  = $clog2(DATA_BITS);
  localparam int MID = (CLKS_PER_BIT - 1) / 2;

  localparam logic [CW-1:0] CNT_S0   = CW'(MID - 1);
  localparam logic [CW-1:0] CNT_S1   = CW'(MID);
  localparam logic [CW-1:0] CNT_DEC  = CW'(MID + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = (STOP_BITS == 2);

  if (CLKS_PER_BIT < 4 || DATA_BITS < 5 || DATA_BITS > 9 ||
      STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_param_check
    $error("uart_rx_cfg: parameter out of range");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t state, state_n;

  logic [1:0]           sync_q;
  logic                 s_rx;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        bit_idx;
  logic                 stop_idx;
  logic                 samp_a, samp_b;
  logic                 maj;
  logic                 at_dec, at_last;
  logic [DATA_BITS-1:0] data_sr;
  logic                 frame_acc;
  logic                 parity_err_r;
  logic                 armed;

  logic store_bit, parity_chk, stop_chk, load_req;

  assign s_rx    = sync_q[1];
  assign at_dec  = (cnt == CNT_DEC);
  assign at_last = (cnt == CNT_LAST);
  // 2-of-3 vote over the samples at MID-1, MID and the live sample at MID+1
  assign maj     = (samp_a & samp_b) | (samp_a & s_rx) | (samp_b & s_rx);
  assign o_Busy  = (state != IDLE);

  always_ff @(posedge i_Clock) begin
    if (i_Reset) sync_q <= '1;
    else         sync_q <= {sync_q[0], i_RX_Serial};
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) state <= IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n    = state;
    store_bit  = 1'b0;
    parity_chk = 1'b0;
    stop_chk   = 1'b0;
    load_req   = 1'b0;
    case (state)
      IDLE: begin
        if (armed && !s_rx) state_n = START;
      end
      START: begin
        if (at_dec && maj)  state_n = IDLE;
        else if (at_last)   state_n = DATA;
      end
      DATA: begin
        if (at_dec) store_bit = 1'b1;
        if (at_last && bit_idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
          state_n = PARITY;
`else
          state_n = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (at_dec)  parity_chk = 1'b1;
        if (at_last) state_n = STOP;
      end
`endif
      STOP: begin
        if (at_dec) begin
          stop_chk = 1'b1;
          // Return on the last stop bit's decision so the next start edge
          // can be caught during the remaining half of the stop bit.
          if (stop_idx == STOP_LAST) begin
            load_req = 1'b1;
            state_n  = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      cnt       <= '0;
      bit_idx   <= '0;
      stop_idx  <= 1'b0;
      samp_a    <= 1'b1;
      samp_b    <= 1'b1;
      data_sr   <= '0;
      frame_acc <= 1'b0;
      armed     <= 1'b0;
    end else begin
      if (state == IDLE || state_n != state || at_last) cnt <= '0;
      else                                              cnt <= cnt + 1'b1;

      if (state != DATA)  bit_idx <= '0;
      else if (at_last)   bit_idx <= bit_idx + 1'b1;

      if (state != STOP)  stop_idx <= 1'b0;
      else if (at_last)   stop_idx <= 1'b1;

      if (cnt == CNT_S0) samp_a <= s_rx;
      if (cnt == CNT_S1) samp_b <= s_rx;

      if (store_bit) data_sr[bit_idx] <= maj;

      if (state == START)         frame_acc <= 1'b0;
      else if (stop_chk && !maj)  frame_acc <= 1'b1;

      // Arming tracks "line seen high since the last start edge", so a
      // frame ending in a low line starts one break frame and then waits
      // for the line to return high.
      if (state == IDLE && state_n == START) armed <= 1'b0;
      else if (s_rx)                         armed <= 1'b1;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge i_Clock) begin
    if (i_Reset)              parity_err_r <= 1'b0;
    else if (state == START)  parity_err_r <= 1'b0;
    else if (parity_chk)      parity_err_r <= maj ^ (^data_sr) ^ (PARITY_ODD != 0);
  end
`else
  assign parity_err_r = 1'b0;
`endif

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      o_RX_Valid   <= 1'b0;
      o_RX_Byte    <= '0;
      o_Frame_Err  <= 1'b0;
      o_Parity_Err <= 1'b0;
      o_Overrun    <= 1'b0;
    end else begin
      if (o_RX_Valid && i_RX_Ready) begin
        o_RX_Valid <= 1'b0;
        o_Overrun  <= 1'b0;
      end
      if (load_req) begin
        if (!o_RX_Valid || i_RX_Ready) begin
          o_RX_Valid   <= 1'b1;
          o_RX_Byte    <= data_sr;
          o_Frame_Err  <= frame_acc | ~maj;
          o_Parity_Err <= parity_err_r;
        end else begin
          o_Overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg -- self-checking bench for uart_rx_cfg at 16 clocks/bit,
// 8 data bits, 1 stop bit. Build with +define+UART_RX_PARITY_EN to cover
// the parity variant (even parity).
module tb_uart_rx_cfg;

  localparam int  CPB  = 16;
  localparam int  DB   = 8;
  localparam bit  PODD = 1'b0;

  logic          clk = 1'b0;
  logic          i_Reset;
  logic          i_RX_Serial;
  logic          i_RX_Ready;
  logic          o_RX_Valid;
  logic [DB-1:0] o_RX_Byte;
  logic          o_Frame_Err;
  logic          o_Parity_Err;
  logic          o_Overrun;
  logic          o_Busy;

  always #5 clk = ~clk;

  uart_rx_cfg #(
    .CLKS_PER_BIT (CPB),
    .DATA_BITS    (DB),
    .STOP_BITS    (1),
    .PARITY_ODD   (0)
  ) dut (
    .i_Clock      (clk),
    .i_Reset      (i_Reset),
    .i_RX_Serial  (i_RX_Serial),
    .i_RX_Ready   (i_RX_Ready),
    .o_RX_Valid   (o_RX_Valid),
    .o_RX_Byte    (o_RX_Byte),
    .o_Frame_Err  (o_Frame_Err),
    .o_Parity_Err (o_Parity_Err),
    .o_Overrun    (o_Overrun),
    .o_Busy       (o_Busy)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [DB-1:0] word;
    logic          ferr;
    logic          perr;
  } exp_t;

  exp_t sb[$];
  exp_t got;
  int   valid_cycles = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every accepted word is compared against the oldest expectation.
  always @(negedge clk) begin
    if (o_RX_Valid) valid_cycles++;
    if (o_RX_Valid && i_RX_Ready && !i_Reset) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got %0h expected no word at %0t", o_RX_Byte, $time);
      end else begin
        got = sb.pop_front();
        check("rx_byte", o_RX_Byte, got.word);
        check("frame_err", o_Frame_Err, got.ferr);
        check("parity_err", o_Parity_Err, got.perr);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic v, input logic glitch);
    i_RX_Serial = v;
    if (glitch) begin
      tick(8);
      i_RX_Serial = ~v;
      tick(1);
      i_RX_Serial = v;
      tick(CPB - 9);
    end else begin
      tick(CPB);
    end
  endtask

  task automatic send_frame(input logic [DB-1:0] data, input logic stop_bit,
                            input logic par_flip, input logic glitch);
    logic par_bit;
    par_bit = (^data) ^ PODD ^ par_flip;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < DB; i++) send_bit(data[i], glitch);
`ifdef UART_RX_PARITY_EN
    send_bit(par_bit, 1'b0);
`endif
    send_bit(stop_bit, 1'b0);
    i_RX_Serial = 1'b1;
  endtask

  task automatic wait_drain(input int max_cycles);
    int n;
    n = 0;
    while (sb.size() != 0 && n < max_cycles) begin
      tick(1);
      n++;
    end
    check("scoreboard_drained", sb.size(), 0);
  endtask

  typedef struct {
    logic [DB-1:0] data;
    logic          stop_bit;
    logic          par_flip;
    logic          glitch;
    logic [DB-1:0] exp_byte;
    logic          exp_ferr;
    logic          exp_perr;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    exp_t e;
    int   n;

    vecs.push_back('{8'hA5, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0});
    vecs.push_back('{8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0});
    vecs.push_back('{8'hFF, 1'b1, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0});
    vecs.push_back('{8'h80, 1'b1, 1'b0, 1'b1, 8'h80, 1'b0, 1'b0});
    vecs.push_back('{8'h01, 1'b1, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0});
    vecs.push_back('{8'h5A, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b1, 1'b0});
    vecs.push_back('{8'hC3, 1'b1, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b0});
`ifdef UART_RX_PARITY_EN
    vecs.push_back('{8'h07, 1'b1, 1'b1, 1'b0, 8'h07, 1'b0, 1'b1});
    vecs.push_back('{8'h07, 1'b1, 1'b0, 1'b0, 8'h07, 1'b0, 1'b0});
`endif

    // Reset state
    i_Reset     = 1'b1;
    i_RX_Serial = 1'b1;
    i_RX_Ready  = 1'b1;
    tick(3);
    check("reset_valid", o_RX_Valid, 0);
    check("reset_byte", o_RX_Byte, 0);
    check("reset_ferr", o_Frame_Err, 0);
    check("reset_perr", o_Parity_Err, 0);
    check("reset_overrun", o_Overrun, 0);
    check("reset_busy", o_Busy, 0);
    i_Reset = 1'b0;
    tick(4);

    // Table-driven frames with the consumer always ready
    foreach (vecs[k]) begin
      v = vecs[k];
      valid_cycles = 0;
      e.word = v.exp_byte;
      e.ferr = v.exp_ferr;
      e.perr = v.exp_perr;
      sb.push_back(e);
      send_frame(v.data, v.stop_bit, v.par_flip, v.glitch);
      tick(CPB);
      wait_drain(50);
      check("valid_pulse_len", valid_cycles, 1);
      check("busy_after_frame", o_Busy, 0);
      check("overrun_clear", o_Overrun, 0);
    end

    // Short low glitch: false start, no word
    tick(CPB);
    i_RX_Serial = 1'b0;
    tick(3);
    i_RX_Serial = 1'b1;
    n = 0;
    while (!o_Busy && n < 8) begin tick(1); n++; end
    check("glitch_busy_rise", o_Busy, 1);
    n = 0;
    while (o_Busy && n < 16) begin tick(1); n++; end
    check("glitch_busy_fall", o_Busy, 0);
    tick(2 * CPB);

    // Bad stop bit followed by a long break: one word, one break word, then quiet
    valid_cycles = 0;
    e.perr = 1'b0;
    e.ferr = 1'b1;
    e.word = 8'h3C; sb.push_back(e);
    e.word = 8'h00; sb.push_back(e);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < DB; i++) send_bit(e.word[i] | (8'h3C >> i) & 1'b1, 1'b0);
`ifdef UART_RX_PARITY_EN
    send_bit((^8'h3C) ^ PODD, 1'b0);
`endif
    i_RX_Serial = 1'b0;
    tick(41 * CPB);
    wait_drain(10);
    check("break_word_count", valid_cycles, 2);
    check("break_disarmed_busy", o_Busy, 0);
    i_RX_Serial = 1'b1;
    tick(3 * CPB);
    check("break_no_extra_word", valid_cycles, 2);
    check("break_end_busy", o_Busy, 0);

    // Overrun: second frame dropped while the first is held
    i_RX_Ready = 1'b0;
    send_frame(8'h11, 1'b1, 1'b0, 1'b0);
    tick(CPB);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0);
    tick(CPB);
    check("ovr_valid_held", o_RX_Valid, 1);
    check("ovr_byte_held", o_RX_Byte, 8'h11);
    check("ovr_flag", o_Overrun, 1);
    check("ovr_ferr", o_Frame_Err, 0);
    e.word = 8'h11; e.ferr = 1'b0; e.perr = 1'b0;
    sb.push_back(e);
    i_RX_Ready = 1'b1;
    tick(1);
    i_RX_Ready = 1'b0;
    check("ovr_valid_cleared", o_RX_Valid, 0);
    check("ovr_flag_cleared", o_Overrun, 0);
    wait_drain(4);

    // Reset during data bit 3 while a word is held
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
    tick(CPB);
    check("pre_reset_valid", o_RX_Valid, 1);
    fork
      send_frame(8'hFF, 1'b1, 1'b0, 1'b0);
      begin
        tick(4 * CPB + 6);
        check("pre_reset_busy", o_Busy, 1);
        i_Reset = 1'b1;
        tick(1);
        i_Reset = 1'b0;
        check("midrst_valid", o_RX_Valid, 0);
        check("midrst_byte", o_RX_Byte, 0);
        check("midrst_ferr", o_Frame_Err, 0);
        check("midrst_perr", o_Parity_Err, 0);
        check("midrst_overrun", o_Overrun, 0);
        check("midrst_busy", o_Busy, 0);
      end
    join
    i_RX_Ready = 1'b1;
    tick(CPB);
    valid_cycles = 0;
    e.word = 8'hC3; e.ferr = 1'b0; e.perr = 1'b0;
    sb.push_back(e);
    send_frame(8'hC3, 1'b1, 1'b0, 1'b0);
    tick(CPB);
    wait_drain(50);
    check("post_reset_words", valid_cycles, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_cfg.md
# uart_rx_cfg

Parametrised UART receiver: next-generation serial-input block for the board-level serial link. Adds configurable data width and stop-bit count, majority-vote sampling, framing/overrun detection, a valid/ready output handshake and an input synchroniser. It sits between the asynchronous RX pin and the byte-consuming logic (FIFO or command parser).

## Interface
- CLKS_PER_BIT, 868: clock cycles per bit (clock freq / baud); minimum 4.
- DATA_BITS, 8: data bits per frame, 5..9, LSB first.
- STOP_BITS, 1: stop bits checked, 1 or 2.
- PARITY_ODD, 0: 0 = even, 1 = odd parity. Used only when the parity feature is compiled in.
- i_Clock  in  1  system clock; all logic on rising edge.
- i_Reset  in  1  synchronous, active-high reset.
- i_RX_Serial  in  1  asynchronous serial line, idle high.
- i_RX_Ready  in  1  consumer accepts the word when high with o_RX_Valid.
- o_RX_Valid  out  1  word held on o_RX_Byte; reset 0.
- o_RX_Byte  out  DATA_BITS  received data; reset 0.
- o_Frame_Err  out  1  a stop bit was sampled low; qualified by o_RX_Valid; reset 0.
- o_Parity_Err  out  1  parity mismatch; qualified by o_RX_Valid; reset 0.
- o_Overrun  out  1  sticky: a completed frame was dropped; reset 0.
- o_Busy  out  1  FSM is not in IDLE; reset 0.

## Operation
- Input passes through a 2-flop synchroniser (reset value 1). Call the synchronised line s_rx.
- Bit counter width is $clog2(CLKS_PER_BIT). MID = (CLKS_PER_BIT-1)/2.
- Majority sampling: in each bit window, take s_rx at counts MID-1, MID and MID+1. The bit value is the 2-of-3 majority, decided at count MID+1.
- States: IDLE, START, DATA, PARITY, STOP.
  - IDLE: the receiver arms only after s_rx is seen high. When armed and s_rx = 0, go to START with count = 0.
  - START: majority 1 means a false start; return to IDLE. Otherwise, at count CLKS_PER_BIT-1, go to DATA with bit index 0.
  - DATA: the majority bit is stored at index i. After DATA_BITS bits, go to PARITY if the feature is compiled in, otherwise to STOP.
  - PARITY: compare the majority bit with the computed parity and latch the result.
  - STOP: check each stop bit. Any 0 sets the frame error. At the decision point of the last stop bit, load outputs and return to IDLE immediately (no wait for the end of the bit).
- Load: if o_RX_Valid = 0, or o_RX_Valid = 1 with i_RX_Ready = 1 in the same cycle, the new word and its error flags replace the output register. Otherwise the word is dropped, the held word is unchanged, and o_Overrun is set.
- Handshake: o_RX_Valid clears on a cycle where o_RX_Valid and i_RX_Ready are both high, unless a load occurs in that same cycle. That same handshake cycle clears o_Overrun.
- Break (line held low through the frame): the frame is delivered as 0 with o_Frame_Err = 1. IDLE stays disarmed until s_rx returns high, so no new frame starts during the break.
- Reset mid-frame: FSM goes to IDLE, the partial word is discarded, and all outputs are forced to their reset values.

## Timing
- Start edge to first sample: 2 synchroniser cycles plus MID-1 counts.
- o_RX_Valid rises the cycle after the decision sample (count MID+1) of the last stop bit.
- o_RX_Byte and the error flags are stable for as long as o_RX_Valid is high.
- Back-to-back frames: ready for the next start edge from the cycle after load, about CLKS_PER_BIT/2 before the nominal end of the stop bit.
- Throughput: one word per frame time, provided i_RX_Ready is high at least once per frame.

## Configuration
- UART_RX_PARITY_EN defined:
  - PARITY state is present; the frame carries one parity bit after the data bits.
  - o_Parity_Err reports a mismatch against PARITY_ODD.
- UART_RX_PARITY_EN undefined:
  - No PARITY state; the frame goes directly from DATA to STOP.
  - o_Parity_Err is tied 0 and PARITY_ODD is ignored.

## Test plan
All scenarios use CLKS_PER_BIT = 16.
- 8N1 frame 0xA5 with i_RX_Ready = 1 -> o_RX_Byte = 0xA5, o_RX_Valid high for 1 cycle, o_Frame_Err = o_Parity_Err = 0.
- Low glitch of 3 cycles, then line high -> no o_RX_Valid; o_Busy falls within 16 cycles.
- Frame 0x3C with stop bit 0, then line held low for 40 bit times -> one word 0x3C with o_Frame_Err = 1; break frame delivered as 0x00 with o_Frame_Err = 1; no further words until line high.
- Frames 0x11 then 0x22 with i_RX_Ready = 0 -> o_RX_Byte stays 0x11 and o_Overrun = 1. Raise i_RX_Ready for 1 cycle -> o_RX_Valid = 0 and o_Overrun = 0.
- UART_RX_PARITY_EN defined, PARITY_ODD = 0: frame 0x07 with parity bit 0 -> o_Parity_Err = 1; same frame with parity bit 1 -> o_Parity_Err = 0.
- i_Reset asserted for 1 cycle during data bit 3 -> all outputs 0 on the next cycle; next frame 0xC3 received clean.
